mac_pipe_sat: RTL
=================

Name: mac_pipe_sat

Overview:
Parametrised, pipelined signed multiply-accumulate unit. It is the successor to the single-stage 12x12/24-bit MAC and adds configurable operand and accumulator widths, an optional multiplier pipeline stage, selectable saturate/wrap overflow handling, a per-sample accumulator clear, and a sticky overflow flag. It sits in the datapath between operand sources (FIFO or memory readout) and result consumers that sample f whenever valid_out is high.

Parameters:
A_WIDTH, 12, signed width of operand a
B_WIDTH, 12, signed width of operand b
ACC_WIDTH, 24, signed accumulator/output width; must be >= A_WIDTH+B_WIDTH
PIPE_MULT, 1, 0 = no product register, 1 = registered product stage
SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clears all state
a  in  A_WIDTH  signed operand, sampled when valid_in=1
b  in  B_WIDTH  signed operand, sampled when valid_in=1
valid_in  in  1  operand pair valid this cycle
clear_acc  in  1  qualified by valid_in; the result is this product alone (accumulator restarts)
f  out  ACC_WIDTH  signed accumulator value
valid_out  out  1  f updated with a new result this cycle
overflow  out  1  sticky: an overflow occurred since the last clear/reset

Behaviour:
- Reset (synchronous, active-high, sampled at posedge): f=0, valid_out=0, overflow=0, all pipeline valid bits=0. In-flight samples are discarded and produce no valid_out. Inputs presented in the reset cycle are ignored.
- Stage 1: register a, b, valid_in, clear_acc.
- Stage 2 (present only if PIPE_MULT=1): register product = a*b, full A_WIDTH+B_WIDTH signed, plus valid and clear.
- Accumulate stage: sign-extend the product to ACC_WIDTH+1. sum = (clear ? 0 : f) + product, computed at ACC_WIDTH+1 bits.
- Latency: a sample accepted at edge N produces valid_out=1 and the new f after edge N+2+PIPE_MULT. The default latency is 3. Throughput is 1 sample/cycle with no stalls. The accumulator feedback path is single-cycle, so back-to-back samples never hazard.
- valid_out is high for exactly one cycle per accepted sample, in order. When no valid sample reaches the accumulate stage, f holds its value and valid_out=0.
- Overflow is detected when sum > 2^(ACC_WIDTH-1)-1 or sum < -2^(ACC_WIDTH-1).
  - SATURATE=1: f clamps to the max or min value respectively.
  - SATURATE=0: f = sum[ACC_WIDTH-1:0] (wrap).
  - In either mode, overflow is set on any overflow event.
- overflow is sticky. It clears only on reset, or when a clear_acc sample is accumulated; that sample sets it again if it overflows itself, which is impossible when ACC_WIDTH >= A_WIDTH+B_WIDTH.
- clear_acc with valid_in=0 is ignored.
- Saturation is applied per step. Subsequent samples accumulate from the clamped value, not from the true sum.
- Bit-growth guarantee: a single product always fits in ACC_WIDTH, including -2^(A-1) * -2^(B-1).
- No X propagation: f and overflow change only on valid accumulate or reset.

Test Plan:
1. Basic accumulation (defaults, latency 3). Stimulus: reset, then (3,4,v=1) followed by (-5,6,v=1). Response: valid_out=1 on the 3rd and 4th cycles after the first sample, with f=12 then f=-18; overflow=0.
2. Bubbles. Stimulus: a=b=2 with the valid_in pattern 1,0,1. Response: f=4, then f held at 4 with valid_out=0, then f=8; the valid_out pattern is 1,0,1 shifted by 3 cycles.
3. Positive overflow.
   - SATURATE=1: nine samples of (1023,1023) after f=180. The 8th result is 8372412; the 9th is clamped to 8388607 and overflow=1. A following (-1024,1023) gives 7341055, and overflow stays 1.
   - Same sequence with SATURATE=0: the 9th result is -7358275, then 8371389; overflow=1.
4. Negative saturation. Stimulus: three samples of (-2048,2047). Response: f=-4192256, then -8384512, then clamped to -8388608; overflow=1. A follow-up sample of (-2048,-2048) with clear_acc=1 gives f=4194304 and overflow=0.
5. Clear mid-stream. Stimulus: accumulate (10,10),(4,20) to f=180, then (2,5) with clear_acc=1, then (1,1). Response: f=100, 180, 10, 11. clear_acc asserted with valid_in=0 has no effect.
6. Reset mid-flight. Stimulus: issue three valid samples on consecutive cycles and assert reset for one cycle on the cycle after the third. Response: no valid_out for any of the three samples, and f=0, overflow=0 after the reset edge. A sample (7,7) issued after reset deasserts yields f=49 with correct latency. Repeat the test with PIPE_MULT=0 and check latency 2.

Source files
------------

// File: rtl/mac_pipe_sat.sv
// Pipelined signed MAC with saturate/wrap overflow and sticky overflow flag; latency 2+PIPE_MULT edges after capture.
// No backpressure: one sample per cycle, the consumer must take f whenever valid_out is high.
module mac_pipe_sat #(
  parameter int A_WIDTH   = 12,
  parameter int B_WIDTH   = 12,
  parameter int ACC_WIDTH = 24,
  parameter int PIPE_MULT = 1,
  parameter int SATURATE  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [A_WIDTH-1:0]   a,
  input  logic signed [B_WIDTH-1:0]   b,
  input  logic                        valid_in,
  input  logic                        clear_acc,
  output logic signed [ACC_WIDTH-1:0] f,
  output logic                        valid_out,
  output logic                        overflow
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // Stage 1: operand capture
  logic signed [A_WIDTH-1:0] a_q;
  logic signed [B_WIDTH-1:0] b_q;
  logic                      s1_vld_q;
  logic                      s1_clr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      s1_vld_q <= 1'b0;
      s1_clr_q <= 1'b0;
    end else begin
      s1_vld_q <= valid_in;
      s1_clr_q <= valid_in & clear_acc;
      if (valid_in) begin
        a_q <= a;
        b_q <= b;
      end
    end
  end

  logic signed [P_WIDTH-1:0] prod_s1;
  assign prod_s1 = P_WIDTH'(a_q) * P_WIDTH'(b_q);

  // Product as seen by the accumulate stage, optionally registered
  logic signed [P_WIDTH-1:0] prod_acc;
  logic                      acc_in_vld;
  logic                      acc_in_clr;

  if (PIPE_MULT != 0) begin : g_pipe
    logic signed [P_WIDTH-1:0] prod_q;
    logic                      s2_vld_q;
    logic                      s2_clr_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        prod_q   <= '0;
        s2_vld_q <= 1'b0;
        s2_clr_q <= 1'b0;
      end else begin
        s2_vld_q <= s1_vld_q;
        s2_clr_q <= s1_clr_q;
        if (s1_vld_q) begin
          prod_q <= prod_s1;
        end
      end
    end

    assign prod_acc   = prod_q;
    assign acc_in_vld = s2_vld_q;
    assign acc_in_clr = s2_clr_q;
  end else begin : g_nopipe
    assign prod_acc   = prod_s1;
    assign acc_in_vld = s1_vld_q;
    assign acc_in_clr = s1_clr_q;
  end

  // Accumulate stage: one extra bit of headroom exposes overflow as a top-bit disagreement
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        acc_vld_q;
  logic                        ovf_q, ovf_d;
  logic signed [ACC_WIDTH:0]   base_ext;
  logic signed [ACC_WIDTH:0]   prod_ext;
  logic signed [ACC_WIDTH:0]   sum;
  logic                        sum_ovf;
  logic signed [ACC_WIDTH-1:0] sum_lim;

  always_comb begin
    base_ext = '0;
    if (!acc_in_clr) begin
      base_ext = (ACC_WIDTH+1)'(acc_q);
    end
    prod_ext = (ACC_WIDTH+1)'(prod_acc);
    sum      = base_ext + prod_ext;
    sum_ovf  = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];

    sum_lim = sum[ACC_WIDTH-1:0];
    if ((SATURATE != 0) && sum_ovf) begin
      sum_lim = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end

    acc_d = acc_q;
    ovf_d = ovf_q;
    if (acc_in_vld) begin
      acc_d = sum_lim;
      ovf_d = (ovf_q & ~acc_in_clr) | sum_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= '0;
      acc_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      acc_vld_q <= acc_in_vld;
      ovf_q     <= ovf_d;
    end
  end

  // Output register keeps the adder/clamp path away from the consumer
  logic signed [ACC_WIDTH-1:0] f_q;
  logic                        vout_q;
  logic                        ovf_out_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      f_q       <= '0;
      vout_q    <= 1'b0;
      ovf_out_q <= 1'b0;
    end else begin
      f_q       <= acc_q;
      vout_q    <= acc_vld_q;
      ovf_out_q <= ovf_q;
    end
  end

  assign f         = f_q;
  assign valid_out = vout_q;
  assign overflow  = ovf_out_q;

endmodule
